// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU: op codes, FSM states
// and bit positions of the flag / condition-code vectors.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REMU = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam int FLG_ZF = 0;
  localparam int FLG_SF = 1;
  localparam int FLG_OF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide step
// per cycle, WIDTH steps per operation. hi/lo share storage between MUL and DIV.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic             is_mul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_nxt_o,
  output logic [WIDTH-1:0] lo_nxt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             mul_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic             div_ge;

  // MUL: hi:lo = accumulator:multiplier, shifted right. DIV: hi = partial
  // remainder, lo = dividend shifting out / quotient shifting in.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    div_ge   = (div_rem >= {1'b0, opnd_q});
    if (mul_q) begin
      hi_nxt_o = mul_sum[WIDTH:1];
      lo_nxt_o = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_nxt_o = div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
      lo_nxt_o = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      mul_q <= 1'b0;
    end else if (kill_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CNT_W'(WIDTH);
      mul_q <= is_mul_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      hi_q   <= '0;
      lo_q   <= is_mul_i ? a_i : b_i;
      opnd_q <= is_mul_i ? b_i : a_i;
    end else if (cnt_q != '0) begin
      hi_q <= hi_nxt_o;
      lo_q <= lo_nxt_o;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and a registered
// condition-code register updated when a set_cc result is consumed.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             set_cc,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [2:0]       op_q, res_op;
  logic             set_cc_q;
  logic [WIDTH-1:0] val_q, res, sum, diff, it_hi, it_lo;
  logic [2:0]       flg_q, cc_q, flg;
  logic             accept, load_res, cc_we, it_start, it_done, ovf;

  function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] r, input logic v);
    logic [2:0] f;
    f         = '0;
    f[FLG_ZF] = (r == '0);
    f[FLG_SF] = r[WIDTH-1];
    f[FLG_OF] = v;
    return f;
  endfunction

  alu_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (it_start),
    .kill_i   (abort),
    .is_mul_i (op == OP_MUL),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .done_o   (it_done),
    .hi_nxt_o (it_hi),
    .lo_nxt_o (it_lo)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    it_start = 1'b0;
    load_res = 1'b0;
    cc_we    = 1'b0;
    case (state_q)
      IDLE: if (in_valid && !abort) begin
        accept = 1'b1;
        if (is_iter_op(op)) begin
          it_start = 1'b1;
          state_d  = ITER;
        end else begin
          load_res = 1'b1;
          state_d  = DONE;
        end
      end
      ITER: if (abort) begin
        state_d = IDLE;
      end else if (it_done) begin
        load_res = 1'b1;
        state_d  = DONE;
      end
      DONE: if (abort) begin
        state_d = IDLE;
      end else if (out_ready) begin
        cc_we   = set_cc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ops read the live inputs at accept; iterative ops read the
  // unit's final-step values on the edge that enters DONE.
  always_comb begin
    res    = '0;
    ovf    = 1'b0;
    res_op = (state_q == ITER) ? op_q : op;
    sum    = alu_b + alu_a;
    diff   = alu_b - alu_a;
    case (res_op)
      OP_ADD: begin
        res = sum;
        ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_b[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_b[WIDTH-1]);
      end
      OP_AND:  res = alu_b & alu_a;
      OP_XOR:  res = alu_b ^ alu_a;
      OP_MUL: begin
        res = it_lo;
        ovf = |it_hi;
      end
      OP_DIVU: res = it_lo;
      OP_REMU: res = it_hi;
      default: res = '0;
    endcase
    flg = mk_flags(res, ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      set_cc_q <= 1'b0;
      val_q    <= '0;
      flg_q    <= '0;
      cc_q     <= '0;
    end else begin
      if (accept) begin
        op_q     <= op;
        set_cc_q <= set_cc;
      end
      if (load_res) begin
        val_q <= res;
        flg_q <= flg;
      end
      if (cc_we) cc_q <= flg_q;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign val_e     = val_q;
  assign zf        = flg_q[FLG_ZF];
  assign sf        = flg_q[FLG_SF];
  assign of        = flg_q[FLG_OF];
  assign cc_zf     = cc_q[FLG_ZF];
  assign cc_sf     = cc_q[FLG_SF];
  assign cc_of     = cc_q[FLG_OF];

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle, parametrised successor to the Y86-64 execute-stage ALU.
- Adds iterative unsigned multiply, divide and remainder alongside add/sub/and/xor.
- Uses a valid/ready handshake on both input and output, plus an internal registered condition-code (CC) register.
- Sits in the execute stage of the upcoming multi-cycle/pipelined core. The stage stalls on in_ready/out_valid.

Parameters:
- WIDTH, 64, operand/result width in bits; legal range ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  3  operation code (see Behaviour)
- set_cc  in  1  update CC register when this op's result is accepted
- alu_a  in  WIDTH  operand A (subtrahend / multiplier / divisor)
- alu_b  in  WIDTH  operand B (minuend / multiplicand / dividend)
- abort  in  1  synchronous kill of the in-flight op
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- val_e  out  WIDTH  result
- zf, sf, of  out  1 each  flags of the current result (valid with out_valid)
- cc_zf, cc_sf, cc_of  out  1 each  registered CC register

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - in_ready=1, out_valid=0.
  - val_e=0.
  - zf=sf=of=0, cc_zf=cc_sf=cc_of=0.
  - Counter=0.
- Op codes, all results WIDTH bits and wrap modulo 2^WIDTH:
  - 000 ADD: B+A
  - 001 SUB: B−A
  - 010 AND: B&A
  - 011 XOR: B^A
  - 100 MUL: low WIDTH bits of unsigned B*A
  - 101 DIVU: B/A
  - 110 REMU: B%A
  - 111 reserved: result 0, flags computed normally
- Flags:
  - zf = (val_e==0).
  - sf = val_e[WIDTH-1].
  - of, ADD: A and B share a sign and the result sign differs.
  - of, SUB: A and B signs differ and the result sign ≠ B sign.
  - of, MUL: 1 if the high WIDTH bits of the full product are non-zero.
  - of, logic/DIVU/REMU/reserved: 0.
- Divide by zero (A=0):
  - DIVU returns all ones. REMU returns B. of=0.
  - The iteration count is unchanged (no early exit).
- FSM states: IDLE, ITER, DONE.
  - IDLE: in_ready=1. On in_valid, latch op, operands and set_cc.
    - Ops 000–011 and 111 go to DONE next cycle (latency 1).
    - Ops 100–110 go to ITER with counter=WIDTH.
  - ITER: one shift-add (MUL) or one restoring-subtract (DIVU/REMU) step per cycle; counter decrements. When counter reaches 1, the next state is DONE. Latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1. val_e and flags are held stable until out_ready. On out_valid&&out_ready, go to IDLE. If the latched set_cc=1, CC takes zf/sf/of on that same edge.
  - in_ready=0 in ITER and DONE. No new request is accepted in the cycle a result is consumed; back-to-back issue rate is one op per 2 cycles minimum.
- abort:
  - Sampled in ITER or DONE: next state is IDLE and out_valid drops next cycle. CC is unchanged even if out_ready is also high that cycle (abort wins).
  - abort in IDLE together with in_valid: the request is not accepted.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- op, alu_a and alu_b changing after accept has no effect.
- Reset asserted mid-ITER/DONE: immediate return to the reset values; CC is cleared.

Decomposition:
- Shared package alu_pkg:
  - op code localparams (OP_ADD … OP_RSVD)
  - FSM state typedef {IDLE, ITER, DONE}
  - flag-index constants for the CC register
- One sub-module, alu_iter_unit:
  - Holds the shift-add multiplier and restoring divider datapath (accumulator, quotient/remainder registers, counter).
  - start/done interface.
  - seq_alu keeps the FSM, handshake, single-cycle ops, flags and CC.

Test Plan (WIDTH=64):
- Reset then ADD, A=0x7FFF_FFFF_FFFF_FFFF, B=1, set_cc=1, out_ready=1:
  - out_valid exactly 1 cycle after accept.
  - val_e=0x8000_0000_0000_0000, sf=1, of=1, zf=0; CC mirrors these after the handshake.
- SUB, A=5, B=5, set_cc=0:
  - val_e=0, zf=1, of=0; CC unchanged from the previous test.
- MUL, A=0x1_0000_0000, B=0x1_0000_0000:
  - out_valid 65 cycles after accept, val_e=0, of=1, zf=1.
- MUL, A=3, B=7 with out_ready held low for 10 cycles:
  - val_e=21 held stable; in_ready stays 0 throughout.
- DIVU, B=100, A=7, then REMU on the same operands:
  - 14 then 2. DIVU with A=0 gives 0xFFFF_FFFF_FFFF_FFFF; REMU with A=0 gives 100.
- DIVU accepted, abort pulsed in the 10th ITER cycle:
  - No out_valid, in_ready=1 next cycle, CC unchanged.
  - rst_n pulsed low mid-ITER: all outputs 0 asynchronously, in_ready=1.
